// File: rtl/timing_loop_nco.sv
// Symbol-timing loop: PI filter on Gardner TED errors steering a phase-accumulator NCO.
// Optional lock detector is built when TIMING_LOCK_DET_EN is defined; otherwise lock_o is tied low.
module timing_loop_nco #(
  parameter int OSF      = 20,
  parameter int WERR     = 18,
  parameter int PW       = 24,
  parameter int KP_SHIFT = 4,
  parameter int KI_SHIFT = 10,
  parameter int INT_LIM  = 32768,
  parameter int CTRL_LIM = 65536,
  parameter int WMU      = 8,
  parameter int LOCK_THR = 2048,
  parameter int LOCK_CNT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   loop_en_i,
  input  logic signed [WERR-1:0] e_in_i,
  input  logic                   e_valid_i,
  output logic                   sym_valid_o,
  output logic [WMU-1:0]         mu_o,
  output logic [PW-1:0]          ctrl_o,
  output logic                   lock_o
);

  localparam int W = PW + 2;
  localparam longint NOM_STEP = ((longint'(1) << PW) + longint'(OSF / 2)) / longint'(OSF);
  localparam logic signed [W-1:0] NOM_W = W'(NOM_STEP);

  // The NCO step must stay positive and the integrator must fit inside the control range.
  if (longint'(CTRL_LIM) >= NOM_STEP / 2 || INT_LIM > CTRL_LIM) begin : g_bad_limits
    $error("timing_loop_nco: CTRL_LIM must be < NOM_STEP/2 and INT_LIM <= CTRL_LIM");
  end

  function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] x, input int lim);
    logic signed [W-1:0] l;
    l = W'(lim);
    if (x > l)       return l;
    else if (x < -l) return -l;
    else             return x;
  endfunction

  logic signed [W-1:0] e_ext, e_p, e_i;
  logic signed [W-1:0] integ_sum, integ_sat, ctrl_sum, ctrl_sat, step;
  logic signed [PW-1:0] integ, ctrl;
  logic [PW-1:0] acc;
  logic [PW:0]   acc_sum;

  assign e_ext     = {{(W-WERR){e_in_i[WERR-1]}}, e_in_i};
  assign e_p       = e_ext >>> KP_SHIFT;
  assign e_i       = e_ext >>> KI_SHIFT;
  assign integ_sum = {{2{integ[PW-1]}}, integ} + e_i;
  assign integ_sat = sat(integ_sum, INT_LIM);
  assign ctrl_sum  = e_p + integ_sat;
  assign ctrl_sat  = sat(ctrl_sum, CTRL_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integ <= '0;
      ctrl  <= '0;
    end else if (!loop_en_i) begin
      integ <= '0;
      ctrl  <= '0;
    end else if (e_valid_i) begin
      integ <= integ_sat[PW-1:0];
      ctrl  <= ctrl_sat[PW-1:0];
    end
  end

  // Step is bounded to (0, 2^PW), so bit PW of the sum is exactly the wrap carry.
  assign step    = NOM_W + {{2{ctrl[PW-1]}}, ctrl};
  assign acc_sum = {1'b0, acc} + step[PW:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      sym_valid_o <= 1'b0;
      mu_o        <= '0;
    end else begin
      acc         <= acc_sum[PW-1:0];
      sym_valid_o <= acc_sum[PW];
      if (acc_sum[PW]) mu_o <= acc_sum[PW-1 -: WMU];
    end
  end

  assign ctrl_o = ctrl;

`ifdef TIMING_LOCK_DET_EN
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic signed [W-1:0] THR_W = W'(LOCK_THR);

  logic [CW-1:0]       lock_cnt, lock_cnt_n;
  logic signed [W-1:0] e_abs;
  logic                lock_q;

  assign e_abs = e_ext[W-1] ? -e_ext : e_ext;

  always_comb begin
    lock_cnt_n = lock_cnt;
    if (!loop_en_i) begin
      lock_cnt_n = '0;
    end else if (e_valid_i) begin
      if (e_abs < THR_W) begin
        if (lock_cnt != CW'(LOCK_CNT)) lock_cnt_n = lock_cnt + 1'b1;
      end else begin
        lock_cnt_n = '0;
      end
    end
  end

  // Lock follows the updated count, so it rises/drops on the edge that consumes the error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= '0;
      lock_q   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_n;
      lock_q   <= loop_en_i && (lock_cnt_n == CW'(LOCK_CNT));
    end
  end

  assign lock_o = lock_q;
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_timing_loop_nco.sv
// Bench for timing_loop_nco: directed scenarios plus random errors against an arithmetic phase/filter model.
module tb_timing_loop_nco;

  localparam longint TWO_PW = 64'd1 << 24;
  localparam longint NOM    = 838861;
  localparam int     MIN_SP = 18;
  localparam int     MAX_SP = 22;
`ifdef TIMING_LOCK_DET_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               loop_en_i = 1'b0;
  logic signed [17:0] e_in_i = '0;
  logic               e_valid_i = 1'b0;
  logic               sym_valid_o;
  logic [7:0]         mu_o;
  logic [23:0]        ctrl_o;
  logic               lock_o;

  timing_loop_nco dut (
    .clk(clk), .reset_n(reset_n), .loop_en_i(loop_en_i), .e_in_i(e_in_i),
    .e_valid_i(e_valid_i), .sym_valid_o(sym_valid_o), .mu_o(mu_o),
    .ctrl_o(ctrl_o), .lock_o(lock_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int last_strobe = 0, first_strobe = 0, last_iv = 0, min_iv = 1000;
  longint m_acc, m_integ, m_ctrl, m_mu;
  bit m_sv, m_lock;
  int m_cnt;

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint x, input longint lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc_no, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_integ = 0; m_ctrl = 0; m_mu = 0; m_sv = 0; m_lock = 0; m_cnt = 0;
    cyc_no = 0; last_strobe = 0; first_strobe = 0; last_iv = 0;
  endtask

  task automatic cyc();
    longint nacc, e;
    @(posedge clk);
    e = longint'(e_in_i);
    nacc = m_acc + NOM + m_ctrl;
    m_sv = (nacc >= TWO_PW);
    if (m_sv) begin
      nacc = nacc - TWO_PW;
      m_mu = nacc / 65536;
    end
    m_acc = nacc;
    if (!loop_en_i) begin
      m_integ = 0; m_ctrl = 0; m_cnt = 0;
    end else if (e_valid_i) begin
      m_integ = clamp(m_integ + fdiv(e, 1024), 32768);
      m_ctrl  = clamp(fdiv(e, 16) + m_integ, 65536);
      if ((e < 0 ? -e : e) < 2048) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
      else m_cnt = 0;
    end
    m_lock = LOCK_ON && (m_cnt >= 16);
    #1;
    cyc_no++;
    chk("sym_valid", sym_valid_o, m_sv);
    chk("mu", mu_o, m_mu);
    chk("ctrl", ctrl_o, m_ctrl & 64'hFF_FFFF);
    chk("lock", lock_o, m_lock);
    if (sym_valid_o) begin
      if (first_strobe == 0) first_strobe = cyc_no;
      if (last_strobe != 0) begin
        last_iv = cyc_no - last_strobe;
        if (last_iv < min_iv) min_iv = last_iv;
        chk("spacing_min", last_iv >= MIN_SP, 1);
        chk("spacing_max", last_iv <= MAX_SP, 1);
      end
      last_strobe = cyc_no;
    end
  endtask

  task automatic wait_strobe();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc();
      seen = sym_valid_o;
    end
    chk("strobe_timeout", seen, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_sv", sym_valid_o, 0);
    chk("rst_mu", mu_o, 0);
    chk("rst_ctrl", ctrl_o, 0);
    chk("rst_lock", lock_o, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    loop_en_i = 1'b0; e_valid_i = 1'b0; e_in_i = '0;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic filter_clear();
    loop_en_i = 1'b0; e_valid_i = 1'b0;
    cyc();
    loop_en_i = 1'b1;
  endtask

  initial begin
    // Scenario 1: free run after reset
    do_reset();
    repeat (45) cyc();
    chk("first_strobe", first_strobe, 20);
    chk("free_period", last_iv, 20);

    // Scenario 2: single +4096 pulse on a strobe
    loop_en_i = 1'b1;
    wait_strobe();
    e_valid_i = 1'b1; e_in_i = 18'sd4096;
    cyc();
    e_valid_i = 1'b0;
    chk("ctrl_260", ctrl_o, 260);
    wait_strobe();
    chk("p2_period_lo", last_iv >= 19, 1);
    chk("p2_period_hi", last_iv <= 20, 1);

    // Scenario 3: -4096 on every strobe
    filter_clear();
    for (int p = 0; p < 5; p++) begin
      wait_strobe();
      e_valid_i = 1'b1; e_in_i = -18'sd4096;
      cyc();
      e_valid_i = 1'b0;
    end
    chk("ctrl_m276", ctrl_o, 24'hFF_FEEC);
    for (int p = 0; p < 20; p++) begin
      wait_strobe();
      e_valid_i = 1'b1; e_in_i = -18'sd4096;
      cyc();
      e_valid_i = 1'b0;
    end

    // Scenario 4: max positive error drives both saturations
    filter_clear();
    min_iv = 1000;
    for (int p = 0; p < 300; p++) begin
      wait_strobe();
      e_valid_i = 1'b1; e_in_i = 18'sd131071;
      cyc();
      e_valid_i = 1'b0;
    end
    chk("ctrl_sat", ctrl_o, 40959);
    chk("sat_min_spacing", min_iv >= 19, 1);

    // Randomised errors, valid timing and loop enable
    for (int i = 0; i < 3000; i++) begin
      loop_en_i = ($urandom_range(0, 99) < 95);
      e_valid_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) e_in_i = 18'($urandom_range(0, 4095)) - 18'sd2048;
      else e_in_i = 18'($urandom());
      cyc();
    end

    // Scenario 5: asynchronous reset mid-symbol with nonzero control
    loop_en_i = 1'b1; e_valid_i = 1'b1; e_in_i = 18'sd131071;
    cyc();
    e_valid_i = 1'b0;
    repeat (7) cyc();
    chk("ctrl_nonzero", ctrl_o != 0, 1);
    do_reset();
    wait_strobe();
    chk("re_first_strobe", first_strobe, 20);
    chk("re_first_mu", mu_o, 0);
    wait_strobe();
    chk("re_period", last_iv, 20);

    // Scenario 6: lock detector
    filter_clear();
    for (int k = 1; k <= 16; k++) begin
      e_valid_i = 1'b1;
      e_in_i = (k % 2 == 0) ? 18'sd100 : -18'sd100;
      cyc();
      if (k == 15) chk("lock_after15", lock_o, 0);
    end
    e_valid_i = 1'b0;
    chk("lock_after16", lock_o, LOCK_ON);
    cyc();
    chk("lock_hold", lock_o, LOCK_ON);
    e_valid_i = 1'b1; e_in_i = 18'sd3000;
    cyc();
    e_valid_i = 1'b0;
    chk("lock_drop", lock_o, 0);
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc_no);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timing_loop_nco.md
Name: timing_loop_nco

Overview:
Symbol-timing recovery loop that closes the Gardner TED feedback path. It consumes the TED timing-error samples and filters them with a proportional-integral (PI) loop filter. The filtered control steers a phase-accumulator NCO, which generates the one-clock-per-symbol strobe sym_valid_o that drives the TED's sym_valid_i input. It also emits a fractional-phase estimate mu_o for a downstream interpolator/decision stage.

Parameters:
OSF, 20, nominal samples per symbol; one input sample per clk.
WERR, 18, width of the signed timing-error input.
PW, 24, NCO phase-accumulator width; NOM_STEP = round(2^PW/OSF), a localparam (838861 at defaults).
KP_SHIFT, 4, proportional gain as an arithmetic right shift of e_in_i.
KI_SHIFT, 10, integral gain as an arithmetic right shift of e_in_i.
INT_LIM, 32768, integrator saturation magnitude (±INT_LIM).
CTRL_LIM, 65536, control-word saturation magnitude (±CTRL_LIM).
WMU, 8, width of mu_o.
LOCK_THR, 2048, lock-detector |error| threshold.
LOCK_CNT, 16, consecutive in-threshold errors required to declare lock.

Ports:
clk  in  1  system clock; one sample per cycle.
reset_n  in  1  asynchronous, active-low reset.
loop_en_i  in  1  1 = closed loop; 0 = free-run at NOM_STEP.
e_in_i  in  WERR  signed timing error from the TED.
e_valid_i  in  1  qualifies e_in_i; 1-clk pulse.
sym_valid_o  out  1  1-clk symbol strobe, fed to the TED's sym_valid_i.
mu_o  out  WMU  unsigned fractional phase, captured at the strobe.
ctrl_o  out  PW  signed current control word (debug/monitor).
lock_o  out  1  timing-lock flag.

Behaviour:
- Reset (asynchronous assert on reset_n low, synchronous release): acc=0, integ=0, ctrl=0; outputs sym_valid_o=0, mu_o=0, ctrl_o=0, lock_o=0, lock counter=0. A reset asserted mid-operation clears all state immediately, with no partial strobe.
- Elaboration check: issue $error if CTRL_LIM >= NOM_STEP/2 or INT_LIM > CTRL_LIM.
- Loop filter, evaluated on every clk with e_valid_i=1 and loop_en_i=1:
  - integ_n = sat_INT(integ + (e_in_i >>> KI_SHIFT)).
  - ctrl_n = sat_CTRL((e_in_i >>> KP_SHIFT) + integ_n).
  - Both are registered, so ctrl takes effect on the next cycle's step (1-cycle latency).
  - Internal sums use PW+2 bits before saturation; no wrap is permitted.
- loop_en_i=0: integ and ctrl are synchronously cleared to 0 each cycle and e_valid_i is ignored. Re-enabling starts the filter from zero.
- NCO, every cycle:
  - step = NOM_STEP + ctrl, always positive by the elaboration check.
  - {carry, acc_n} = acc + step; acc <= acc_n.
  - sym_valid_o <= carry, registered: high for exactly the cycle after a wrap edge.
  - Sign convention: positive error increases step, so the next strobe comes earlier.
- mu_o <= acc_n[PW-1 -: WMU] on carry; held otherwise.
- ctrl_o mirrors the ctrl register.
- Simultaneous events:
  - e_valid_i arriving in the same cycle as a carry is legal. The step already in use is unchanged; the new ctrl applies from the following cycle.
  - e_valid_i need not coincide with sym_valid_o. Every qualified pulse is processed.
- Strobe spacing: always between floor(2^PW/(NOM_STEP+CTRL_LIM)) and ceil(2^PW/(NOM_STEP-CTRL_LIM)) clocks. Two strobes are never adjacent.

Optional Feature:
TIMING_LOCK_DET_EN:
- Defined:
  - On each qualified e_valid_i, |e_in_i| < LOCK_THR increments a saturating counter; otherwise the counter clears to 0 and lock_o drops on the next cycle.
  - lock_o rises the cycle after the counter reaches LOCK_CNT.
  - loop_en_i=0 clears both the counter and lock_o.
- Undefined: no counter logic is generated; lock_o is tied to 0.

Test Plan:
1. Reset release, loop_en_i=0, no errors -> first sym_valid_o high on the cycle after the 20th clk edge; subsequent strobes every 20 clks; ctrl_o=0; mu_o=0 at the first strobe (acc_n=4).
2. loop_en_i=1, a single e_in_i=+4096 pulse -> ctrl_o=260 one cycle later (256+4). Next strobe period is 19 or 20 clks, with the earlier arrival consistent with step 839121.
3. e_in_i=-4096 on every strobe -> integ falls by 4 per symbol; after 5 pulses ctrl_o=-276. Strobe spacing grows to 21 clks over time.
4. e_in_i=131071 held on every strobe -> integ saturates at 32768 and ctrl_o saturates at 40959 (8191+32768). No wrap; strobe spacing stays ≥19.
5. Assert reset_n low mid-symbol with ctrl≠0 -> all outputs 0 asynchronously, in the same cycle. After release, behaviour is identical to scenario 1.
6. TIMING_LOCK_DET_EN defined, 16 errors of |e|=100 -> lock_o=1 the cycle after the 16th. One e=3000 -> lock_o=0 next cycle. Macro undefined -> lock_o constant 0.
